// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU front-end sequencer: opcodes, FSM states
// and the opcode classifier used to pick the execution path.
package alu_op_sequencer_pkg;

    localparam logic [4:0] OP_OR   = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd1;
    localparam logic [4:0] OP_ADD  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_ADDU = 5'd4;
    localparam logic [4:0] OP_MUL  = 5'd5;
    localparam logic [4:0] OP_DIV  = 5'd6;

    // Opcodes up to OP_LAST_SINGLE finish in one ALU cycle; up to
    // OP_LAST_LEGAL go to a multi-cycle unit; anything above is illegal.
    localparam logic [4:0] OP_LAST_SINGLE = OP_ADDU;
    localparam logic [4:0] OP_LAST_LEGAL  = OP_DIV;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OPC_SINGLE  = 2'd0,
        OPC_MULTI   = 2'd1,
        OPC_ILLEGAL = 2'd2
    } op_class_t;

    function automatic op_class_t classify_op(input logic [4:0] op);
        if (op <= OP_LAST_SINGLE) begin
            return OPC_SINGLE;
        end else if (op <= OP_LAST_LEGAL) begin
            return OPC_MULTI;
        end else begin
            return OPC_ILLEGAL;
        end
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and multi-cycle-unit signals of the sequencer bundled as one
// interface. The sequencer takes the slave side; its environment the master.
interface alu_op_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int RW = 2 * DATA_WIDTH;

    logic                  req_valid;
    logic                  req_ready;
    logic [4:0]            req_op;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;
    logic [4:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [RW-1:0]         comb_result;
    logic                  mc_start;
    logic                  mc_sel;
    logic                  mc_done;
    logic [RW-1:0]         mc_result;
    logic [RW-1:0]         z_out;
    logic                  z_valid;
    logic                  busy;
    logic                  err_illegal;
    logic                  err_timeout;

    modport master (
        output req_valid, req_op, req_a, req_b, comb_result, mc_done, mc_result,
        input  req_ready, alu_op, alu_a, alu_b, mc_start, mc_sel,
               z_out, z_valid, busy, err_illegal, err_timeout
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, comb_result, mc_done, mc_result,
        output req_ready, alu_op, alu_a, alu_b, mc_start, mc_sel,
               z_out, z_valid, busy, err_illegal, err_timeout
    );

endinterface

// File: rtl/alu_op_sequencer_watchdog.sv
// Timeout watchdog for multi-cycle operations: counts cycles spent waiting
// and flags the last permitted cycle.
module alu_op_sequencer_watchdog #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Cycle counter: cleared as a multi-cycle op launches, advances while waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = i_count && (r_count == LAST_COUNT);

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU front-end sequencer: accepts one op per handshake, holds operands
// stable on the ALU, captures single-cycle results directly and drives the
// start/done handshake of the MUL/DIV units under a timeout watchdog.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_op_sequencer_if.slave    bus
);
    localparam int RW = 2 * DATA_WIDTH;

    state_t                r_state, w_state_next;
    logic [4:0]            r_alu_op, w_alu_op_next;
    logic [DATA_WIDTH-1:0] r_alu_a, w_alu_a_next;
    logic [DATA_WIDTH-1:0] r_alu_b, w_alu_b_next;
    logic [RW-1:0]         r_z, w_z_next;
    logic                  r_z_valid, w_z_valid_next;
    logic                  r_mc_start, w_mc_start_next;
    logic                  r_mc_sel, w_mc_sel_next;
    logic                  r_err_illegal, w_err_illegal_next;
    logic                  r_err_timeout, w_err_timeout_next;
    logic                  w_accept;
    logic                  w_wd_clear;
    logic                  w_wd_count;
    logic                  w_expired;

    assign w_accept   = bus.req_valid && (r_state == ST_IDLE);
    assign w_wd_clear = (r_state == ST_START);
    assign w_wd_count = (r_state == ST_WAIT);

    alu_op_sequencer_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_wd_clear),
        .i_count  (w_wd_count),
        .o_expired(w_expired)
    );

    // Next-state and next-output decode; pulses default low every cycle
    always_comb begin
        w_state_next       = r_state;
        w_alu_op_next      = r_alu_op;
        w_alu_a_next       = r_alu_a;
        w_alu_b_next       = r_alu_b;
        w_z_next           = r_z;
        w_mc_sel_next      = r_mc_sel;
        w_z_valid_next     = 1'b0;
        w_mc_start_next    = 1'b0;
        w_err_illegal_next = 1'b0;
        w_err_timeout_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_alu_op_next = bus.req_op;
                    w_alu_a_next  = bus.req_a;
                    w_alu_b_next  = bus.req_b;
                    case (classify_op(bus.req_op))
                        OPC_SINGLE: begin
                            w_state_next = ST_EXEC;
                        end
                        OPC_MULTI: begin
                            w_state_next    = ST_START;
                            w_mc_start_next = 1'b1;
                            w_mc_sel_next   = (bus.req_op == OP_DIV);
                        end
                        default: begin
                            w_state_next       = ST_ERR;
                            w_err_illegal_next = 1'b1;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                // ALU has had one full cycle on the latched operands
                w_z_next       = bus.comb_result;
                w_z_valid_next = 1'b1;
                w_state_next   = ST_IDLE;
            end
            ST_START: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion beats expiry when both land in the same cycle
                if (bus.mc_done) begin
                    w_z_next       = bus.mc_result;
                    w_z_valid_next = 1'b1;
                    w_mc_sel_next  = 1'b0;
                    w_state_next   = ST_IDLE;
                end else if (w_expired) begin
                    w_err_timeout_next = 1'b1;
                    w_mc_sel_next      = 1'b0;
                    w_state_next       = ST_IDLE;
                end
            end
            ST_ERR: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_alu_op      <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_z           <= '0;
            r_z_valid     <= 1'b0;
            r_mc_start    <= 1'b0;
            r_mc_sel      <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_alu_op      <= w_alu_op_next;
            r_alu_a       <= w_alu_a_next;
            r_alu_b       <= w_alu_b_next;
            r_z           <= w_z_next;
            r_z_valid     <= w_z_valid_next;
            r_mc_start    <= w_mc_start_next;
            r_mc_sel      <= w_mc_sel_next;
            r_err_illegal <= w_err_illegal_next;
            r_err_timeout <= w_err_timeout_next;
        end
    end

    assign bus.req_ready   = (r_state == ST_IDLE);
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.alu_op      = r_alu_op;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.z_out       = r_z;
    assign bus.z_valid     = r_z_valid;
    assign bus.mc_start    = r_mc_start;
    assign bus.mc_sel      = r_mc_sel;
    assign bus.err_illegal = r_err_illegal;
    assign bus.err_timeout = r_err_timeout;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: scoreboard of expected Z values
// pushed as stimulus is driven and popped when z_valid is seen.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int DW = 32;
    localparam int RW = 64;
    localparam int TO = 40;

    logic          clk;
    logic          reset;
    int            tests_run = 0;
    int            tests_failed = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] model_z = '0;

    int   n_mc_start = 0;
    int   n_z_valid  = 0;
    int   n_err_ill  = 0;
    int   n_err_to   = 0;
    int   n_overlap  = 0;
    int   n_long     = 0;
    logic p_mc_start = 1'b0;
    logic p_z_valid  = 1'b0;
    logic p_err_ill  = 1'b0;
    logic p_err_to   = 1'b0;

    alu_op_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    alu_op_sequencer #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference single-cycle ALU driving comb_result from the latched operands
    function automatic logic [RW-1:0] alu_ref(input logic [4:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [RW-1:0] sa;
        logic [RW-1:0] sb;
        sa = {{DW{a[DW-1]}}, a};
        sb = {{DW{b[DW-1]}}, b};
        case (op)
            OP_OR:   return {{DW{1'b0}}, a | b};
            OP_AND:  return {{DW{1'b0}}, a & b};
            OP_ADD:  return sa + sb;
            OP_SUB:  return sa - sb;
            OP_ADDU: return {{DW{1'b0}}, a} + {{DW{1'b0}}, b};
            default: return '0;
        endcase
    endfunction

    assign bus.comb_result = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

    // Pulse monitor, sampling 2 time units after each rising edge
    always @(posedge clk) begin
        #2;
        if (bus.mc_start === 1'b1)    n_mc_start <= n_mc_start + 1;
        if (bus.z_valid === 1'b1)     n_z_valid  <= n_z_valid + 1;
        if (bus.err_illegal === 1'b1) n_err_ill  <= n_err_ill + 1;
        if (bus.err_timeout === 1'b1) n_err_to   <= n_err_to + 1;
        if ((int'(bus.mc_start === 1'b1) + int'(bus.z_valid === 1'b1) +
             int'(bus.err_illegal === 1'b1) + int'(bus.err_timeout === 1'b1)) > 1)
            n_overlap <= n_overlap + 1;
        if ((p_mc_start && bus.mc_start === 1'b1) || (p_z_valid && bus.z_valid === 1'b1) ||
            (p_err_ill && bus.err_illegal === 1'b1) || (p_err_to && bus.err_timeout === 1'b1))
            n_long <= n_long + 1;
        p_mc_start <= (bus.mc_start === 1'b1);
        p_z_valid  <= (bus.z_valid === 1'b1);
        p_err_ill  <= (bus.err_illegal === 1'b1);
        p_err_to   <= (bus.err_timeout === 1'b1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (bus.z_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_z: got %h expected 0", bus.z_out);
        end
        tests_run++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b} !== '0) begin
            tests_failed++;
            $display("FAIL reset_alu: got op=%h a=%h b=%h expected all 0", bus.alu_op, bus.alu_a, bus.alu_b);
        end
        tests_run++;
        if ({bus.z_valid, bus.mc_start, bus.mc_sel, bus.busy, bus.err_illegal, bus.err_timeout,
             bus.req_ready} !== 7'b0000001) begin
            tests_failed++;
            $display("FAIL reset_flags: got zv,st,sel,busy,ill,to,rdy=%b expected 0000001",
                     {bus.z_valid, bus.mc_start, bus.mc_sel, bus.busy, bus.err_illegal, bus.err_timeout, bus.req_ready});
        end
        reset   = 1'b0;
        model_z = '0;
        tick();
        $display("[TB] reset done");
    endtask

    task automatic test_add();
        logic [RW-1:0] exp_z;
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_ready_idle: got %b expected 1", bus.req_ready);
        end
        drive_req(OP_ADD, 32'd5, 32'd7);
        exp_q.push_back(64'd12);
        tick();
        bus.req_valid = 1'b0;
        tests_run++;
        if ({bus.req_ready, bus.busy, bus.z_valid} !== 3'b010) begin
            tests_failed++;
            $display("FAIL add_exec_flags: got rdy,busy,zv=%b expected 010", {bus.req_ready, bus.busy, bus.z_valid});
        end
        tests_run++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {OP_ADD, 32'd5, 32'd7}) begin
            tests_failed++;
            $display("FAIL add_alu_latch: got op=%h a=%h b=%h expected op=2 a=5 b=7", bus.alu_op, bus.alu_a, bus.alu_b);
        end
        tick();
        tests_run++;
        if ({bus.req_ready, bus.busy, bus.z_valid} !== 3'b101) begin
            tests_failed++;
            $display("FAIL add_done_flags: got rdy,busy,zv=%b expected 101", {bus.req_ready, bus.busy, bus.z_valid});
        end
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL add_z: got %h with scoreboard empty", bus.z_out);
        end else begin
            exp_z = exp_q.pop_front();
            if (bus.z_out !== exp_z) begin
                tests_failed++;
                $display("FAIL add_z: got %h expected %h", bus.z_out, exp_z);
            end
            model_z = exp_z;
        end
        tick();
        tests_run++;
        if ({bus.z_valid, bus.z_out} !== {1'b0, model_z}) begin
            tests_failed++;
            $display("FAIL add_z_hold: got zv=%b z=%h expected zv=0 z=%h", bus.z_valid, bus.z_out, model_z);
        end
        $display("[TB] ADD 5+7 -> z_out=%h", bus.z_out);
    endtask

    task automatic test_div_timeout();
        int c_to;
        c_to = n_err_to;
        drive_req(OP_DIV, 32'd100, 32'd7);
        tick();
        bus.req_valid = 1'b0;
        tests_run++;
        if ({bus.mc_start, bus.mc_sel, bus.busy} !== 3'b111) begin
            tests_failed++;
            $display("FAIL div_start: got start,sel,busy=%b expected 111", {bus.mc_start, bus.mc_sel, bus.busy});
        end
        repeat (TO) tick();
        tests_run++;
        if ({bus.err_timeout, bus.busy, bus.req_ready, bus.mc_sel} !== 4'b0101) begin
            tests_failed++;
            $display("FAIL div_wait_last: got to,busy,rdy,sel=%b expected 0101",
                     {bus.err_timeout, bus.busy, bus.req_ready, bus.mc_sel});
        end
        tick();
        tests_run++;
        if ({bus.err_timeout, bus.z_valid, bus.busy, bus.req_ready} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL div_timeout: got to,zv,busy,rdy=%b expected 1001",
                     {bus.err_timeout, bus.z_valid, bus.busy, bus.req_ready});
        end
        tests_run++;
        if (bus.z_out !== model_z) begin
            tests_failed++;
            $display("FAIL div_z_kept: got %h expected %h", bus.z_out, model_z);
        end
        bus.mc_done   = 1'b1;
        bus.mc_result = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        bus.mc_done   = 1'b0;
        tests_run++;
        if ({bus.z_valid, bus.err_timeout, bus.busy, bus.z_out} !== {3'b000, model_z}) begin
            tests_failed++;
            $display("FAIL late_done_ignored: got zv,to,busy=%b z=%h expected 000 z=%h",
                     {bus.z_valid, bus.err_timeout, bus.busy}, bus.z_out, model_z);
        end
        tick();
        tests_run++;
        if (n_err_to - c_to !== 1) begin
            tests_failed++;
            $display("FAIL div_timeout_count: got %0d timeout pulses expected 1", n_err_to - c_to);
        end
        $display("[TB] DIV no-done -> timeout, z_out=%h", bus.z_out);
    endtask

    task automatic test_mul();
        logic [RW-1:0] exp_z;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int c_start;
        a = 32'hFFFF_FFFD;
        b = 32'd4;
        c_start = n_mc_start;
        drive_req(OP_MUL, a, b);
        tick();
        bus.req_valid = 1'b0;
        tests_run++;
        if ({bus.mc_start, bus.mc_sel, bus.busy, bus.req_ready} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL mul_start: got start,sel,busy,rdy=%b expected 1010",
                     {bus.mc_start, bus.mc_sel, bus.busy, bus.req_ready});
        end
        repeat (33) tick();
        tests_run++;
        if ({bus.mc_start, bus.mc_sel, bus.busy, bus.z_valid} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL mul_wait: got start,sel,busy,zv=%b expected 0010",
                     {bus.mc_start, bus.mc_sel, bus.busy, bus.z_valid});
        end
        tests_run++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {OP_MUL, a, b}) begin
            tests_failed++;
            $display("FAIL mul_operands: got op=%h a=%h b=%h expected op=5 a=%h b=%h",
                     bus.alu_op, bus.alu_a, bus.alu_b, a, b);
        end
        bus.mc_done   = 1'b1;
        bus.mc_result = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF4);
        tick();
        bus.mc_done   = 1'b0;
        bus.mc_result = '0;
        tests_run++;
        if ({bus.z_valid, bus.err_timeout, bus.busy, bus.req_ready} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL mul_done_flags: got zv,to,busy,rdy=%b expected 1001",
                     {bus.z_valid, bus.err_timeout, bus.busy, bus.req_ready});
        end
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL mul_z: got %h with scoreboard empty", bus.z_out);
        end else begin
            exp_z = exp_q.pop_front();
            if (bus.z_out !== exp_z) begin
                tests_failed++;
                $display("FAIL mul_z: got %h expected %h", bus.z_out, exp_z);
            end
            model_z = exp_z;
        end
        tick();
        tests_run++;
        if (n_mc_start - c_start !== 1) begin
            tests_failed++;
            $display("FAIL mul_start_count: got %0d start cycles expected 1", n_mc_start - c_start);
        end
        $display("[TB] MUL -3*4 -> z_out=%h", bus.z_out);
    endtask

    task automatic test_illegal();
        logic [4:0] ill_ops[3];
        int c_start;
        int c_zv;
        int c_ill;
        ill_ops = '{5'd7, 5'd20, 5'd31};
        c_start = n_mc_start;
        c_zv    = n_z_valid;
        c_ill   = n_err_ill;
        for (int i = 0; i < 3; i++) begin
            drive_req(ill_ops[i], 32'h1234_5678, 32'h0000_0001);
            tick();
            bus.req_valid = 1'b0;
            tests_run++;
            if ({bus.err_illegal, bus.mc_start, bus.busy, bus.req_ready} !== 4'b1010) begin
                tests_failed++;
                $display("FAIL illegal_pulse op=%0d: got ill,start,busy,rdy=%b expected 1010",
                         ill_ops[i], {bus.err_illegal, bus.mc_start, bus.busy, bus.req_ready});
            end
            tick();
            tests_run++;
            if ({bus.err_illegal, bus.busy, bus.req_ready, bus.z_out} !== {3'b001, model_z}) begin
                tests_failed++;
                $display("FAIL illegal_after op=%0d: got ill,busy,rdy=%b z=%h expected 001 z=%h",
                         ill_ops[i], {bus.err_illegal, bus.busy, bus.req_ready}, bus.z_out, model_z);
            end
            $display("[TB] illegal op %0d dropped", ill_ops[i]);
        end
        tick();
        tests_run++;
        if ((n_mc_start != c_start) || (n_z_valid != c_zv) || (n_err_ill - c_ill != 3)) begin
            tests_failed++;
            $display("FAIL illegal_counts: got start=%0d zv=%0d ill=%0d expected 0 0 3",
                     n_mc_start - c_start, n_z_valid - c_zv, n_err_ill - c_ill);
        end
    endtask

    task automatic test_reset_in_wait();
        int c_zv;
        c_zv = n_z_valid;
        drive_req(OP_MUL, 32'd9, 32'd9);
        tick();
        bus.req_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        tests_run++;
        if ({bus.z_out, bus.alu_op, bus.alu_a, bus.alu_b} !== '0) begin
            tests_failed++;
            $display("FAIL rst_wait_data: got z=%h op=%h a=%h b=%h expected all 0",
                     bus.z_out, bus.alu_op, bus.alu_a, bus.alu_b);
        end
        tests_run++;
        if ({bus.z_valid, bus.mc_start, bus.mc_sel, bus.busy, bus.err_illegal, bus.err_timeout,
             bus.req_ready} !== 7'b0000001) begin
            tests_failed++;
            $display("FAIL rst_wait_flags: got zv,st,sel,busy,ill,to,rdy=%b expected 0000001",
                     {bus.z_valid, bus.mc_start, bus.mc_sel, bus.busy, bus.err_illegal, bus.err_timeout, bus.req_ready});
        end
        model_z       = '0;
        reset         = 1'b0;
        bus.mc_done   = 1'b1;
        bus.mc_result = 64'd81;
        tick();
        bus.mc_done   = 1'b0;
        tests_run++;
        if ({bus.z_valid, bus.busy, bus.err_timeout, bus.z_out} !== {3'b000, model_z}) begin
            tests_failed++;
            $display("FAIL rst_late_done: got zv,busy,to=%b z=%h expected 000 z=0",
                     {bus.z_valid, bus.busy, bus.err_timeout}, bus.z_out);
        end
        tick();
        tests_run++;
        if (n_z_valid != c_zv) begin
            tests_failed++;
            $display("FAIL rst_no_zvalid: got %0d z_valid pulses expected 0", n_z_valid - c_zv);
        end
        $display("[TB] reset during WAIT -> aborted, z_out=%h", bus.z_out);
    endtask

    task automatic test_held_valid();
        logic [RW-1:0] exp_z;
        int c_to;
        c_to = n_err_to;
        drive_req(OP_MUL, 32'd6, 32'd7);
        tick();
        tests_run++;
        if ({bus.mc_start, bus.mc_sel, bus.req_ready} !== 3'b100) begin
            tests_failed++;
            $display("FAIL held_start: got start,sel,rdy=%b expected 100", {bus.mc_start, bus.mc_sel, bus.req_ready});
        end
        drive_req(OP_ADD, 32'd1, 32'd2);
        for (int i = 1; i <= TO; i++) begin
            tick();
            tests_run++;
            if (bus.req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL held_ready_low wait_cycle=%0d: got %b expected 0", i, bus.req_ready);
            end
        end
        bus.mc_done   = 1'b1;
        bus.mc_result = 64'd42;
        exp_q.push_back(64'd42);
        tick();
        bus.mc_done   = 1'b0;
        tests_run++;
        if ({bus.z_valid, bus.err_timeout, bus.req_ready} !== 3'b101) begin
            tests_failed++;
            $display("FAIL held_done_wins: got zv,to,rdy=%b expected 101", {bus.z_valid, bus.err_timeout, bus.req_ready});
        end
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL held_mul_z: got %h with scoreboard empty", bus.z_out);
        end else begin
            exp_z = exp_q.pop_front();
            if (bus.z_out !== exp_z) begin
                tests_failed++;
                $display("FAIL held_mul_z: got %h expected %h", bus.z_out, exp_z);
            end
            model_z = exp_z;
        end
        $display("[TB] MUL 6*7 done on last WAIT cycle -> z_out=%h", bus.z_out);
        exp_q.push_back(64'd3);
        tick();
        bus.req_valid = 1'b0;
        tests_run++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.busy, bus.req_ready} !== {OP_ADD, 32'd1, 32'd2, 2'b10}) begin
            tests_failed++;
            $display("FAIL held_second_accept: got op=%h a=%h b=%h busy,rdy=%b expected op=2 a=1 b=2 busy,rdy=10",
                     bus.alu_op, bus.alu_a, bus.alu_b, {bus.busy, bus.req_ready});
        end
        tick();
        tests_run++;
        if (exp_q.size() == 0 || bus.z_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL held_add_z: got zv=%b z=%h, expected a z_valid matching the scoreboard", bus.z_valid, bus.z_out);
        end else begin
            exp_z = exp_q.pop_front();
            if (bus.z_out !== exp_z) begin
                tests_failed++;
                $display("FAIL held_add_z: got %h expected %h", bus.z_out, exp_z);
            end
            model_z = exp_z;
        end
        tests_run++;
        if (n_err_to != c_to) begin
            tests_failed++;
            $display("FAIL held_no_timeout: got %0d timeout pulses expected 0", n_err_to - c_to);
        end
        $display("[TB] held ADD 1+2 -> z_out=%h", bus.z_out);
        tick();
    endtask

    task automatic test_back_to_back();
        localparam int N = 5;
        logic [4:0]    ops[N];
        logic [DW-1:0] as[N];
        logic [DW-1:0] bs[N];
        logic [RW-1:0] exp_z;
        int idx;
        int got;
        int cyc;
        ops = '{OP_OR, OP_AND, OP_SUB, OP_ADDU, OP_ADD};
        for (int i = 0; i < N; i++) begin
            as[i] = $urandom;
            bs[i] = $urandom;
        end
        idx = 0;
        got = 0;
        cyc = 0;
        while (got < N && cyc < 4 * N + 10) begin
            if (bus.z_valid === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_z: got %h with scoreboard empty", bus.z_out);
                end else begin
                    exp_z = exp_q.pop_front();
                    if (bus.z_out !== exp_z) begin
                        tests_failed++;
                        $display("FAIL b2b_z op#%0d: got %h expected %h", got, bus.z_out, exp_z);
                    end
                    model_z = exp_z;
                end
                $display("[TB] b2b result #%0d z_out=%h", got, bus.z_out);
                got++;
            end
            if (idx < N) begin
                drive_req(ops[idx], as[idx], bs[idx]);
                if (bus.req_ready === 1'b1) begin
                    exp_q.push_back(alu_ref(ops[idx], as[idx], bs[idx]));
                    idx++;
                end
            end else begin
                bus.req_valid = 1'b0;
            end
            if (got < N) begin
                tick();
                cyc++;
            end
        end
        bus.req_valid = 1'b0;
        tests_run++;
        if (got != N) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results expected %0d", got, N);
        end
        tests_run++;
        if (cyc != 2 * N) begin
            tests_failed++;
            $display("FAIL b2b_throughput: got %0d cycles expected %0d", cyc, 2 * N);
        end
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.mc_done   = 1'b0;
        bus.mc_result = '0;
        test_reset();
        test_add();
        test_div_timeout();
        test_mul();
        test_illegal();
        test_reset_in_wait();
        test_held_valid();
        test_back_to_back();
        tick();
        tests_run++;
        if (n_overlap != 0 || n_long != 0) begin
            tests_failed++;
            $display("FAIL pulse_rules: got %0d overlapping and %0d over-long pulse cycles expected 0 0", n_overlap, n_long);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drained: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
